// File: rtl/fetch_stage_if.sv
// Decode-side handshake bundle between fetch_stage and its consumer.
// The master drives the queue head; the slave returns outReady.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            outValid;
    logic            outReady;
    logic [XLEN-1:0] outPC;
    logic [31:0]     outInstr;

    modport master (
        output outValid,
        output outPC,
        output outInstr,
        input  outReady
    );

    modport slave (
        input  outValid,
        input  outPC,
        input  outInstr,
        output outReady
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC generator feeding a DEPTH-entry instruction queue.
// Optional FETCH_PERF_EN adds fetchCount/flushCount perf counters.
module fetch_stage #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter int              PC_STEP      = 1,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetchEn,
    output logic [XLEN-1:0]            imemAddr,
    input  logic [31:0]                imemData,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirectPC,
    fetch_stage_if.master              deq,
`ifdef FETCH_PERF_EN
    output logic [31:0]                fetchCount,
    output logic [31:0]                flushCount,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] fetchPC;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [XLEN-1:0] pcQ    [DEPTH];
    logic [31:0]     instrQ [DEPTH];
    logic            pop;
    logic            push;

    assign imemAddr = fetchPC;
    assign pop  = deq.outValid & deq.outReady;
    assign push = fetchEn & ~redirect & ((count < CW'(DEPTH)) | pop);

    assign deq.outValid = (count != '0);
    assign deq.outPC    = deq.outValid ? pcQ[head] : '0;
    assign deq.outInstr = deq.outValid ? instrQ[head] : NOP;

    // Queue storage needs no reset: every read is masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pcQ[tail]    <= fetchPC;
            instrQ[tail] <= imemData;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPC <= RESET_VECTOR;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else if (redirect) begin
            fetchPC <= redirectPC;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tail    <= tail + AW'(1);
                fetchPC <= fetchPC + XLEN'(PC_STEP);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchCount <= '0;
            flushCount <= '0;
        end else begin
            if (push) begin
                fetchCount <= fetchCount + 32'd1;
            end
            if (redirect) begin
                flushCount <= flushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (reset vector 0 and
// all-ones) share control inputs; imem returns address + 100.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetchEn;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        outReady;

    logic [31:0] imemAddrA, imemDataA;
    logic [31:0] imemAddrB, imemDataB;
    logic [2:0]  countA, countB;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCountA, flushCountA;
    logic [31:0] fetchCountB, flushCountB;
`endif

    int nChecks = 0;
    int nErrors = 0;

    fetch_stage_if #(.XLEN(32)) ifA ();
    fetch_stage_if #(.XLEN(32)) ifB ();

    assign ifA.outReady = outReady;
    assign ifB.outReady = outReady;
    assign imemDataA = imemAddrA + 32'd100;
    assign imemDataB = imemAddrB + 32'd100;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN(32), .DEPTH(4), .PC_STEP(1), .RESET_VECTOR(32'h0)
    ) dutA (
        .clk(clk), .rst(rst), .fetchEn(fetchEn),
        .imemAddr(imemAddrA), .imemData(imemDataA),
        .redirect(redirect), .redirectPC(redirectPC),
        .deq(ifA),
`ifdef FETCH_PERF_EN
        .fetchCount(fetchCountA), .flushCount(flushCountA),
`endif
        .count(countA)
    );

    fetch_stage #(
        .XLEN(32), .DEPTH(4), .PC_STEP(1), .RESET_VECTOR(32'hFFFF_FFFF)
    ) dutB (
        .clk(clk), .rst(rst), .fetchEn(fetchEn),
        .imemAddr(imemAddrB), .imemData(imemDataB),
        .redirect(redirect), .redirectPC(redirectPC),
        .deq(ifB),
`ifdef FETCH_PERF_EN
        .fetchCount(fetchCountB), .flushCount(flushCountB),
`endif
        .count(countB)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        fetchEn    = 1'b0;
        redirect   = 1'b0;
        redirectPC = 32'h0;
        outReady   = 1'b0;
        step();
        check("rst valid", 64'(ifA.outValid), 64'd0);
        check("rst pc", 64'(ifA.outPC), 64'd0);
        check("rst instr", 64'(ifA.outInstr), 64'h13);
        check("rst addr", 64'(imemAddrA), 64'd0);
        check("rst count", 64'(countA), 64'd0);
        check("rst addrB", 64'(imemAddrB), 64'hFFFF_FFFF);

        // fetchEn low holds the PC
        rst = 1'b0;
        step();
        check("hold addr", 64'(imemAddrA), 64'd0);
        check("hold count", 64'(countA), 64'd0);

        // streaming: one instruction per cycle
        fetchEn  = 1'b1;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream valid", 64'(ifA.outValid), 64'd1);
            check("stream pc", 64'(ifA.outPC), 64'(i));
            check("stream instr", 64'(ifA.outInstr), 64'(100 + i));
            check("stream count", 64'(countA), 64'd1);
            if (i == 0) check("wrap pc0", 64'(ifB.outPC), 64'hFFFF_FFFF);
            if (i == 1) check("wrap pc1", 64'(ifB.outPC), 64'd0);
        end

        // back-pressure fills the queue
        rst = 1'b1;
        step();
        rst      = 1'b0;
        outReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("fill count", 64'(countA), 64'(i < 3 ? i + 1 : 4));
            check("fill pc", 64'(ifA.outPC), 64'd0);
        end
        check("full addr", 64'(imemAddrA), 64'd4);
        outReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("drain pc", 64'(ifA.outPC), 64'(i));
            check("drain count", 64'(countA), 64'd4);
        end

        // count 3, then redirect with concurrent pop
        fetchEn = 1'b0;
        step();
        check("pre-redir count", 64'(countA), 64'd3);
        check("pre-redir pc", 64'(ifA.outPC), 64'd5);
        fetchEn    = 1'b1;
        redirect   = 1'b1;
        redirectPC = 32'h40;
        step();
        check("redir count", 64'(countA), 64'd0);
        check("redir addr", 64'(imemAddrA), 64'h40);
        check("redir valid", 64'(ifA.outValid), 64'd0);
        check("redir instr", 64'(ifA.outInstr), 64'h13);
        redirect = 1'b0;
        step();
        check("redir pc", 64'(ifA.outPC), 64'h40);
        check("redir data", 64'(ifA.outInstr), 64'hA4);

        // async reset with two entries queued
        outReady = 1'b0;
        step();
        check("pre-rst count", 64'(countA), 64'd2);
        rst = 1'b1;
        #1;
        check("async valid", 64'(ifA.outValid), 64'd0);
        check("async count", 64'(countA), 64'd0);
        check("async addr", 64'(imemAddrA), 64'd0);
        check("async addrB", 64'(imemAddrB), 64'hFFFF_FFFF);
        step();
        rst      = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("post pc", 64'(ifA.outPC), 64'd9);
        fetchEn  = 1'b0;
        redirect = 1'b1;
        step();
        step();
        redirect = 1'b0;
        check("flush addr", 64'(imemAddrA), 64'h40);
        check("flush count", 64'(countA), 64'd0);
`ifdef FETCH_PERF_EN
        check("fetchCount", 64'(fetchCountA), 64'd10);
        check("flushCount", 64'(flushCountA), 64'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 nChecks, nErrors);
        $finish;
    end
endmodule
